// File: rtl/lcd_cfah_pkg.sv
// Shared definitions for the character-LCD driver: FSM states, bus-phase
// encoding, default timing constants and common instruction opcodes.
package lcd_cfah_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_EN,
    WR_HOLD,
    PL_SETUP,
    PL_EN,
    PL_HOLD,
    DONE
  } drv_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EN,
    PH_HOLD
  } phase_e;

  localparam int unsigned T_SETUP_DEF      = 2;
  localparam int unsigned T_EN_HIGH_DEF    = 12;
  localparam int unsigned T_HOLD_DEF       = 2;
  localparam int unsigned POLL_TIMEOUT_DEF = 4096;

  localparam logic [7:0] LCD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_HOME         = 8'h02;
  localparam logic [7:0] LCD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] LCD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_MODE   = 8'h06;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_bus_phase.sv
// Setup / enable-high / hold sequencer for one LCD bus access; emits a
// one-cycle pulse on the last cycle of each phase.
module lcd_bus_phase
  import lcd_cfah_pkg::*;
#(
  parameter int unsigned T_SETUP   = T_SETUP_DEF,
  parameter int unsigned T_EN_HIGH = T_EN_HIGH_DEF,
  parameter int unsigned T_HOLD    = T_HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic setup_end,
  output logic en_end,
  output logic done
);

  localparam int unsigned MAXT = max3(T_SETUP, T_EN_HIGH, T_HOLD);
  localparam int unsigned CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  phase_e          phase, phase_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_IDLE;
      cnt   <= '0;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    last      = 1'b0;
    phase_nxt = phase;
    cnt_nxt   = cnt + CW'(1);
    unique case (phase)
      PH_IDLE: begin
        cnt_nxt = '0;
        if (start) phase_nxt = PH_SETUP;
      end
      PH_SETUP: begin
        last = (cnt == CW'(T_SETUP - 1));
        if (last) begin
          phase_nxt = PH_EN;
          cnt_nxt   = '0;
        end
      end
      PH_EN: begin
        last = (cnt == CW'(T_EN_HIGH - 1));
        if (last) begin
          phase_nxt = PH_HOLD;
          cnt_nxt   = '0;
        end
      end
      PH_HOLD: begin
        last = (cnt == CW'(T_HOLD - 1));
        // A start on the final hold cycle chains straight into the next access.
        if (last) begin
          phase_nxt = start ? PH_SETUP : PH_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        phase_nxt = PH_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign setup_end = (phase == PH_SETUP) && last;
  assign en_end    = (phase == PH_EN) && last;
  assign done      = (phase == PH_HOLD) && last;

endmodule

// File: rtl/lcd_cfah_driver.sv
// HD44780-style LCD driver: writes one byte, then polls the busy flag until
// it clears or the poll budget is exhausted.
module lcd_cfah_driver
  import lcd_cfah_pkg::*;
#(
  parameter int unsigned G_T_SETUP      = T_SETUP_DEF,
  parameter int unsigned G_T_EN_HIGH    = T_EN_HIGH_DEF,
  parameter int unsigned G_T_HOLD       = T_HOLD_DEF,
  parameter int unsigned G_POLL_TIMEOUT = POLL_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_wdata,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_timeout,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  inout  logic [7:0] io_lcd_data,
  output logic       o_lcd_on
);

  localparam int unsigned PW_RAW = $clog2(G_POLL_TIMEOUT + 1);
  localparam int unsigned PW     = (PW_RAW < 1) ? 1 : PW_RAW;

  drv_state_e    state, state_nxt;
  logic          rs_q;
  logic [7:0]    wdata_q;
  logic          busy_q;
  logic          timeout_q;
  logic          lcd_on_q;
  logic [PW-1:0] poll_cnt;

  logic          phase_start;
  logic          accept;
  logic          repoll;
  logic          set_timeout;
  logic          ph_setup_end;
  logic          ph_en_end;
  logic          ph_done;
  logic          bus_drive;

  lcd_bus_phase #(
    .T_SETUP   (G_T_SETUP),
    .T_EN_HIGH (G_T_EN_HIGH),
    .T_HOLD    (G_T_HOLD)
  ) u_phase (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (phase_start),
    .setup_end (ph_setup_end),
    .en_end    (ph_en_end),
    .done      (ph_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rs_q      <= 1'b0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      poll_cnt  <= '0;
      lcd_on_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lcd_on_q <= 1'b1;
      if (accept) begin
        rs_q      <= i_rs;
        wdata_q   <= i_wdata;
        timeout_q <= 1'b0;
        poll_cnt  <= '0;
      end
      if (repoll)      poll_cnt  <= poll_cnt + PW'(1);
      if (set_timeout) timeout_q <= 1'b1;
      // Busy flag is captured on the final enable-high cycle of a poll read.
      if (state == PL_EN && ph_en_end) busy_q <= io_lcd_data[7];
    end
  end

  always_comb begin
    state_nxt   = state;
    phase_start = 1'b0;
    accept      = 1'b0;
    repoll      = 1'b0;
    set_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          accept      = 1'b1;
          phase_start = 1'b1;
          state_nxt   = WR_SETUP;
        end
      end
      WR_SETUP: if (ph_setup_end) state_nxt = WR_EN;
      WR_EN:    if (ph_en_end)    state_nxt = WR_HOLD;
      WR_HOLD: begin
        if (ph_done) begin
          phase_start = 1'b1;
          state_nxt   = PL_SETUP;
        end
      end
      PL_SETUP: if (ph_setup_end) state_nxt = PL_EN;
      PL_EN:    if (ph_en_end)    state_nxt = PL_HOLD;
      PL_HOLD: begin
        if (ph_done) begin
          if (!busy_q) begin
            state_nxt = DONE;
          end else if (poll_cnt < PW'(G_POLL_TIMEOUT)) begin
            repoll      = 1'b1;
            phase_start = 1'b1;
            state_nxt   = PL_SETUP;
          end else begin
            set_timeout = 1'b1;
            state_nxt   = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus is driven only during the write access; read states release it as rw rises.
  assign bus_drive   = (state == WR_SETUP) || (state == WR_EN) || (state == WR_HOLD);
  assign io_lcd_data = bus_drive ? wdata_q : 8'hzz;

  assign o_ready   = (state == IDLE);
  assign o_done    = (state == DONE);
  assign o_timeout = timeout_q;
  assign o_lcd_rs  = bus_drive ? rs_q : 1'b0;
  assign o_lcd_rw  = (state == PL_SETUP) || (state == PL_EN) || (state == PL_HOLD);
  assign o_lcd_en  = (state == WR_EN) || (state == PL_EN);
  assign o_lcd_on  = lcd_on_q;

endmodule

// File: tb/tb_lcd_cfah_driver.sv
// Scoreboard bench for lcd_cfah_driver with a behavioural LCD busy-flag emulator.
module tb_lcd_cfah_driver;

  localparam int T_S  = 2;
  localparam int T_E  = 12;
  localparam int T_H  = 2;
  localparam int T_TO = 4;
  localparam int ACC  = T_S + T_E + T_H;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         polls;
    logic       timeout;
    longint     t_acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_rs = 1'b0;
  logic [7:0] i_wdata = 8'h00;
  logic       o_ready, o_done, o_timeout, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
  wire  [7:0] lcd_data;

  logic       sel_lcd = 1'b0;
  logic       emu_busy = 1'b0;
  int         busy_dur = 10;
  longint     busy_until = 0;
  logic [7:0] emu_out;

  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  assign emu_out  = {sel_lcd | emu_busy, 7'h00};
  assign lcd_data = o_lcd_rw ? emu_out : 8'hzz;

  always #5 clk = ~clk;

  lcd_cfah_driver #(
    .G_T_SETUP      (T_S),
    .G_T_EN_HIGH    (T_E),
    .G_T_HOLD       (T_H),
    .G_POLL_TIMEOUT (T_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_rs        (i_rs),
    .i_wdata     (i_wdata),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_timeout   (o_timeout),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_en    (o_lcd_en),
    .io_lcd_data (lcd_data),
    .o_lcd_on    (o_lcd_on)
  );

  task automatic checkOutput(input string name, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  // Reference: the poll that sees the flag clear is the first whose sample
  // point (last en-high cycle) lies at or beyond the busy duration after the write.
  function automatic int expPolls(input logic sel, input int dur);
    if (sel) return -1;
    for (int k = 1; k <= T_TO + 1; k++)
      if (dur <= T_H + T_S + T_E - 1 + (k - 1) * ACC) return k;
    return -1;
  endfunction

  int   mon_wr_cnt, mon_polls, mon_en_run, mon_bad_en, bad_dir, bad_bus;
  logic mon_wr_rs, prev_en, prev_rw;
  logic [7:0] mon_wr_data;

  initial begin
    bad_dir = 0;
    bad_bus = 0;
  end

  // Monitor: emulates the LCD side and scores each completed transaction.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_wr_cnt = 0; mon_polls = 0; mon_en_run = 0; mon_bad_en = 0;
      prev_en = 1'b0; prev_rw = 1'b0; emu_busy = 1'b0; busy_until = 0;
    end else begin
      if (o_lcd_rw && lcd_data !== emu_out) bad_bus++;
      if (o_lcd_en && prev_en && o_lcd_rw !== prev_rw) bad_dir++;
      if (o_lcd_en && !prev_en) begin
        mon_en_run = 1;
        if (!o_lcd_rw) begin
          mon_wr_cnt++;
          mon_wr_rs   = o_lcd_rs;
          mon_wr_data = lcd_data;
        end else begin
          mon_polls++;
        end
      end else if (o_lcd_en) begin
        mon_en_run++;
      end
      if (!o_lcd_en && prev_en) begin
        if (mon_en_run != T_E) mon_bad_en++;
        if (!prev_rw) busy_until = $time + longint'(busy_dur) * 10;
      end
      if (o_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          int   ep;
          e  = exp_q.pop_front();
          ep = (e.polls < 0) ? T_TO + 1 : e.polls;
          checkOutput("write_count", mon_wr_cnt, 1);
          checkOutput("write_rs", mon_wr_rs, e.rs);
          checkOutput("write_data", mon_wr_data, e.data);
          checkOutput("poll_count", mon_polls, ep);
          checkOutput("timeout_flag", o_timeout, e.timeout);
          checkOutput("latency", ($time + 5 - e.t_acc) / 10, ACC * (1 + ep) + 1);
          checkOutput("en_high_width_errs", mon_bad_en, 0);
        end
        mon_wr_cnt = 0; mon_polls = 0; mon_bad_en = 0;
      end
      prev_en  = o_lcd_en;
      prev_rw  = o_lcd_rw;
      emu_busy = ($time < busy_until);
    end
  end

  task automatic waitReady();
    for (int i = 0; i < 400 && !o_ready; i++) @(negedge clk);
    if (!o_ready) checkOutput("ready_wait", 0, 1);
  endtask

  task automatic applyStimulus(input logic rs, input logic [7:0] data, input int dur,
                               input logic sel, input logic glitch);
    exp_t e;
    int   d0;
    waitReady();
    @(negedge clk);
    busy_dur = dur;
    sel_lcd  = sel;
    i_rs     = rs;
    i_wdata  = data;
    i_start  = 1'b1;
    @(posedge clk);
    e.t_acc   = $time;
    e.rs      = rs;
    e.data    = data;
    e.polls   = expPolls(sel, dur);
    e.timeout = (e.polls < 0);
    exp_q.push_back(e);
    d0 = done_cnt;
    #1;
    i_start = 1'b0;
    i_rs    = ~rs;
    i_wdata = ~data;
    checkOutput("timeout_clear_on_accept", o_timeout, 0);
    if (glitch) begin
      for (int i = 0; i < 100 && !(o_lcd_en && !o_lcd_rw); i++) @(negedge clk);
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) checkOutput("done_wait", 0, 1);
  endtask

  task automatic randomDur(output int dur);
    case ($urandom_range(0, 3))
      0:       dur = $urandom_range(1, 12);
      1:       dur = $urandom_range(20, 28);
      2:       dur = $urandom_range(36, 44);
      default: dur = 100;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dur;
    int d0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", o_ready, 1);
    checkOutput("reset_done", o_done, 0);
    checkOutput("reset_timeout", o_timeout, 0);
    checkOutput("reset_en", o_lcd_en, 0);
    checkOutput("reset_rw", o_lcd_rw, 0);
    checkOutput("reset_rs", o_lcd_rs, 0);
    checkOutput("reset_lcd_on", o_lcd_on, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("lcd_on_after_reset", o_lcd_on, 1);

    applyStimulus(1'b0, 8'h38, 10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h41, 24, 1'b0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      randomDur(dur);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), dur, 1'b0, 1'b0);
    end

    applyStimulus(1'b0, 8'h01, 10, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("timeout_sticky_idle", o_timeout, 1);
    applyStimulus(1'b0, 8'h0C, 5, 1'b0, 1'b0);

    applyStimulus(1'b1, 8'h5A, 8, 1'b0, 1'b1);

    waitReady();
    @(negedge clk);
    busy_dur = 100;
    sel_lcd  = 1'b0;
    i_rs     = 1'b0;
    i_wdata  = 8'h06;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < 200 && !(o_lcd_en && o_lcd_rw); i++) @(negedge clk);
    checkOutput("reached_poll_en", o_lcd_en && o_lcd_rw, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_en_low", o_lcd_en, 0);
    checkOutput("abort_rw_low", o_lcd_rw, 0);
    checkOutput("abort_ready", o_ready, 1);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", done_cnt, d0);

    applyStimulus(1'b0, 8'h02, 15, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    checkOutput("bus_contention_errs", bad_bus, 0);
    checkOutput("rw_toggle_while_en_errs", bad_dir, 0);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
